// File: rtl/link_pkg.sv
// Constants shared by the link transmitter muxer and the receive-side output_demuxer.
package link_pkg;

    localparam logic [3:0] CH_IDLE = 4'h0;
    localparam logic [3:0] CH_LO   = 4'h1;
    localparam logic [3:0] CH_MID  = 4'h2;
    localparam logic [3:0] CH_HI   = 4'h3;

    localparam logic [7:0] FILLER_BYTE = 8'hEE;

    localparam logic [1:0] ERR_BADCH   = 2'b01;
    localparam logic [1:0] ERR_DUP     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic {
        StIdle,
        StCollect
    } demux_state_e;

    // Seen-mask bit for a data channel; zero for idle and illegal tags.
    function automatic logic [2:0] ch_onehot(input logic [3:0] ch);
        case (ch)
            CH_LO:   return 3'b001;
            CH_MID:  return 3'b010;
            CH_HI:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/frame_timeout.sv
// Mid-frame stall counter: expires on the tick that would bring the count to TIMEOUT.
module frame_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic arst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned Width = $clog2(TIMEOUT + 1);

    logic [Width-1:0] cnt_q;

    assign expired = tick && !clear && (cnt_q == Width'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (arst) begin
            cnt_q <= '0;
        end else if (clear || expired) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/output_demuxer.sv
// Reassembles channel-tagged bytes into 24-bit words and flags bad/duplicate/stalled frames.
// Define OUTPUT_DEMUXER_TIMEOUT_EN to enable the mid-frame timeout (err_code 11).
module output_demuxer
    import link_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        in_valid,
    input  logic [3:0]  channel,
    input  logic [7:0]  input_data,
    output logic [23:0] output_data,
    output logic        out_valid,
    output logic        err,
    output logic [1:0]  err_code
);

    demux_state_e    state_q, state_d;
    logic [2:0]      mask_q, mask_d;
    logic [2:0][7:0] slots_q, slots_d, slots_wr;
    logic [23:0]     output_data_q, output_data_d;
    logic            out_valid_q, out_valid_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;

    logic [2:0] ch_bit;
    logic [1:0] idx;
    logic       accepted, illegal, dup, complete, timeout;

    assign ch_bit   = ch_onehot(channel);
    assign idx      = channel[1:0] - 2'd1;
    assign accepted = in_valid && (ch_bit != 3'b000);
    assign illegal  = in_valid && (channel > CH_HI);
    assign dup      = accepted && (state_q == StCollect) && ((mask_q & ch_bit) != 3'b000);
    assign complete = accepted && !dup && ((mask_q | ch_bit) == 3'b111);

`ifdef OUTPUT_DEMUXER_TIMEOUT_EN
    frame_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_frame_timeout (
        .clk     (clk),
        .arst    (arst),
        .clear   (accepted || (state_q == StIdle)),
        .tick    ((state_q == StCollect) && !accepted),
        .expired (timeout)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout        = 1'b0;
`endif

    always_comb begin
        slots_wr = slots_q;
        if (accepted) begin
            slots_wr[idx] = input_data;
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q       <= StIdle;
            mask_q        <= '0;
            slots_q       <= '0;
            output_data_q <= '0;
            out_valid_q   <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= 2'b00;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            slots_q       <= slots_d;
            output_data_q <= output_data_d;
            out_valid_q   <= out_valid_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        slots_d = slots_wr;
        if (accepted) begin
            if (complete) begin
                mask_d  = 3'b000;
                state_d = StIdle;
            end else if (dup) begin
                mask_d  = ch_bit;
                state_d = StCollect;
            end else begin
                mask_d  = mask_q | ch_bit;
                state_d = StCollect;
            end
        end else if (timeout) begin
            mask_d  = 3'b000;
            state_d = StIdle;
        end
    end

    // A timeout in the same cycle as an illegal tag reports the timeout.
    always_comb begin
        output_data_d = output_data_q;
        out_valid_d   = 1'b0;
        err_d         = 1'b0;
        err_code_d    = err_code_q;
        if (complete) begin
            output_data_d = slots_wr;
            out_valid_d   = 1'b1;
        end else if (dup) begin
            err_d      = 1'b1;
            err_code_d = ERR_DUP;
        end else if (timeout) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end else if (illegal) begin
            err_d      = 1'b1;
            err_code_d = ERR_BADCH;
        end
    end

    assign output_data = output_data_q;
    assign out_valid   = out_valid_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_output_demuxer.sv
// Randomized self-checking bench for output_demuxer against a frame-level reference model.
module tb_output_demuxer;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        arst;
    logic        in_valid;
    logic [3:0]  channel;
    logic [7:0]  input_data;
    logic [23:0] output_data;
    logic        out_valid;
    logic        err;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    output_demuxer #(
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .in_valid    (in_valid),
        .channel     (channel),
        .input_data  (input_data),
        .output_data (output_data),
        .out_valid   (out_valid),
        .err         (err),
        .err_code    (err_code)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: which channels of the current frame have arrived, and for how long
    // the frame has been waiting for its next byte.
    logic [7:0]  m_bytes [3];
    bit          m_seen  [3];
    int          m_idle;
    logic [23:0] m_data;
    logic        m_valid;
    logic        m_err;
    logic [1:0]  m_code;

    task automatic cycle(input logic r, input logic v, input logic [3:0] ch,
                         input logic [7:0] d);
        int k;
        arst       = r;
        in_valid   = v;
        channel    = ch;
        input_data = d;
        @(posedge clk);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (r) begin
            m_seen = '{0, 0, 0};
            m_idle = 0;
            m_data = 24'h0;
            m_code = 2'b00;
        end else if (v && ch >= 1 && ch <= 3) begin
            k      = int'(ch) - 1;
            m_idle = 0;
            if (m_seen[k]) begin
                m_seen = '{0, 0, 0};
                m_err  = 1'b1;
                m_code = 2'b10;
            end
            m_seen[k]  = 1;
            m_bytes[k] = d;
            if (m_seen[0] && m_seen[1] && m_seen[2]) begin
                m_data  = {m_bytes[2], m_bytes[1], m_bytes[0]};
                m_valid = 1'b1;
                m_seen  = '{0, 0, 0};
            end
        end else begin
            if (m_seen[0] || m_seen[1] || m_seen[2]) begin
                m_idle++;
`ifdef OUTPUT_DEMUXER_TIMEOUT_EN
                if (m_idle == int'(TO)) begin
                    m_seen = '{0, 0, 0};
                    m_idle = 0;
                    m_err  = 1'b1;
                    m_code = 2'b11;
                end
`endif
            end
            if (v && ch > 3 && !m_err) begin
                m_err  = 1'b1;
                m_code = 2'b01;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 4'h1, 8'h5A);
            checks++;
            if ({output_data, out_valid, err, err_code} !== {24'h0, 1'b0, 1'b0, 2'b00}) begin
                $display("FAIL reset cyc%0d: got data=%h v=%b e=%b c=%b want all zero",
                         i, output_data, out_valid, err, err_code);
            end else passed++;
        end
    endtask

    task automatic run_seq(input string name, input logic [3:0] chs[], input logic [7:0] ds[]);
        for (int i = 0; i < chs.size(); i++) begin
            cycle(1'b0, 1'b1, chs[i], ds[i]);
            checks++;
            if ({output_data, out_valid, err, err_code} !== {m_data, m_valid, m_err, m_code})
            begin
                $display("FAIL %s step%0d: got data=%h v=%b e=%b c=%b want data=%h v=%b e=%b c=%b",
                         name, i, output_data, out_valid, err, err_code,
                         m_data, m_valid, m_err, m_code);
            end else passed++;
        end
    endtask

    task automatic test_in_order();
        run_seq("in_order", '{4'h1, 4'h2, 4'h3}, '{8'h11, 8'h22, 8'h33});
        checks++;
        if (output_data !== 24'h332211) begin
            $display("FAIL in_order_word: got %h want 332211", output_data);
        end else passed++;
    endtask

    task automatic test_out_of_order();
        run_seq("out_of_order", '{4'h3, 4'h1, 4'h0, 4'h2}, '{8'hC3, 8'hA1, 8'hEE, 8'hB2});
        checks++;
        if (output_data !== 24'hC3B2A1) begin
            $display("FAIL out_of_order_word: got %h want c3b2a1", output_data);
        end else passed++;
    endtask

    task automatic test_duplicate();
        run_seq("duplicate", '{4'h1, 4'h1, 4'h2, 4'h3}, '{8'h01, 8'h02, 8'h03, 8'h04});
        checks++;
        if (output_data !== 24'h040302) begin
            $display("FAIL duplicate_word: got %h want 040302", output_data);
        end else passed++;
    endtask

    task automatic test_illegal();
        run_seq("illegal", '{4'h1, 4'h5, 4'h2, 4'hF, 4'h3}, '{8'h10, 8'h55, 8'h20, 8'h66, 8'h30});
        checks++;
        if (output_data !== 24'h302010) begin
            $display("FAIL illegal_word: got %h want 302010", output_data);
        end else passed++;
    endtask

    task automatic test_timeout();
        int n_to = 0;
        run_seq("timeout_start", '{4'h1}, '{8'hAA});
        for (int i = 0; i < TO + 2; i++) begin
            cycle(1'b0, (i % 2) == 0, 4'h0, 8'hEE);
            if (err && err_code == 2'b11) n_to++;
            checks++;
            if ({output_data, out_valid, err, err_code} !== {m_data, m_valid, m_err, m_code})
            begin
                $display("FAIL timeout idle%0d: got v=%b e=%b c=%b want v=%b e=%b c=%b",
                         i, out_valid, err, err_code, m_valid, m_err, m_code);
            end else passed++;
        end
        run_seq("timeout_after", '{4'h2, 4'h3}, '{8'hBB, 8'hCC});
        checks++;
`ifdef OUTPUT_DEMUXER_TIMEOUT_EN
        if (n_to != 1) $display("FAIL timeout_count: got %0d want 1", n_to);
        else passed++;
`else
        if (n_to != 0) $display("FAIL timeout_count: got %0d want 0", n_to);
        else passed++;
`endif
        // Flush whatever partial frame remains so later tests start clean.
        cycle(1'b1, 1'b0, 4'h0, 8'h00);
    endtask

    task automatic test_reset_midframe();
        run_seq("midframe", '{4'h1, 4'h2}, '{8'h71, 8'h72});
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 4'h3, 8'h73);
            checks++;
            if ({output_data, out_valid, err, err_code} !== {24'h0, 1'b0, 1'b0, 2'b00}) begin
                $display("FAIL midframe_reset cyc%0d: got data=%h v=%b e=%b c=%b want zero",
                         i, output_data, out_valid, err, err_code);
            end else passed++;
        end
        run_seq("midframe_after", '{4'h3}, '{8'h73});
        checks++;
        if (out_valid !== 1'b0) $display("FAIL midframe_no_valid: got %b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] chs[];
        logic [7:0] ds[];
        int nv = 0;
        cycle(1'b1, 1'b0, 4'h0, 8'h00);
        chs = new[15];
        ds  = new[15];
        for (int f = 0; f < 5; f++) begin
            int rot = f % 3;
            for (int j = 0; j < 3; j++) begin
                chs[f*3+j] = 4'((j + rot) % 3 + 1);
                ds[f*3+j]  = 8'($urandom);
            end
        end
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 1'b1, chs[i], ds[i]);
            if (out_valid) nv++;
            checks++;
            if ({output_data, out_valid, err, err_code} !== {m_data, m_valid, m_err, m_code})
            begin
                $display("FAIL b2b step%0d: got data=%h v=%b e=%b want data=%h v=%b e=%b",
                         i, output_data, out_valid, err, m_data, m_valid, m_err);
            end else passed++;
        end
        checks++;
        if (nv != 5) $display("FAIL b2b_count: got %0d want 5", nv);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic       r, v;
            logic [3:0] ch;
            r = ($urandom_range(0, 149) == 0);
            v = ($urandom_range(0, 9) < 7);
            if (i % 50 > 42) v = 1'b0;
            ch = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
            cycle(r, v, ch, 8'($urandom));
            checks++;
            if ({output_data, out_valid, err, err_code} !== {m_data, m_valid, m_err, m_code})
            begin
                $display("FAIL random step%0d: got data=%h v=%b e=%b c=%b want data=%h v=%b e=%b c=%b",
                         i, output_data, out_valid, err, err_code,
                         m_data, m_valid, m_err, m_code);
            end else passed++;
        end
    endtask

    initial begin
        arst       = 1'b1;
        in_valid   = 1'b0;
        channel    = 4'h0;
        input_data = 8'h00;
        m_seen     = '{0, 0, 0};
        m_bytes    = '{8'h0, 8'h0, 8'h0};
        m_idle     = 0;
        m_data     = 24'h0;
        m_valid    = 1'b0;
        m_err      = 1'b0;
        m_code     = 2'b00;
        #1;
        test_reset();
        test_in_order();
        test_out_of_order();
        test_duplicate();
        test_illegal();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/output_demuxer.md
# output_demuxer

Receive-side counterpart of the transmitter's channel muxer. Accepts a stream of channel-tagged bytes (channel 1 → bits 7:0, 2 → 15:8, 3 → 23:16) and reassembles them into a 24-bit word. A word is published only once all three channels are collected. Bad channels, duplicate channels and stalled frames are flagged. Sits between the link byte receiver and the downstream 24-bit data consumer.

## Interface
Parameters:
- TIMEOUT, 255: idle cycles allowed mid-frame before the partial frame is dropped. Range 1..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- arst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input_data/channel are valid this cycle.
- channel  in  4  channel tag: 0 = idle/filler, 1..3 = data slot, 4..15 = illegal.
- input_data  in  8  payload byte.
- output_data  out  24  last completed word; holds between frames.
- out_valid  out  1  one-cycle pulse: output_data was updated this cycle.
- err  out  1  one-cycle error pulse.
- err_code  out  2  reason, valid while err=1: 01 illegal channel, 10 duplicate channel, 11 timeout. Holds its last value otherwise.

## Operation
- Internal state:
  - three byte slots;
  - a 3-bit seen mask;
  - a timeout counter.
- FSM: IDLE (mask=0) and COLLECT (mask≠0).
- Accepted byte: in_valid=1 and channel∈{1,2,3}.
  - IDLE: store the byte in its slot, set its mask bit, go to COLLECT.
  - COLLECT, bit not yet set: store the byte, set the bit.
  - COLLECT, bit already set: duplicate. Pulse err with code 10. Discard the other slots. The mask becomes only this channel and the byte is stored, so a new frame starts with it. Stay in COLLECT.
- Completion: the accepted byte that makes mask=111 does the following.
  - On the same edge: output_data ← {slot3, slot2, slot1} including the new byte, out_valid=1, mask cleared, go to IDLE.
- channel=0 with in_valid=1:
  - Ignored silently, no error.
  - The payload (normally 8'hEE filler) is discarded.
- channel 4..15 with in_valid=1:
  - err pulse with code 01.
  - Byte dropped.
  - The mask is untouched.
- in_valid=0: channel and input_data are ignored.
- Timeout:
  - The counter clears on every accepted byte and in IDLE.
  - It increments on every COLLECT cycle with no accepted byte. Idle, illegal and invalid cycles all count.
  - When it would reach TIMEOUT: mask cleared, go to IDLE, err pulse with code 11, counter cleared.
- Priority within one cycle:
  - An accepted byte beats the timeout. The counter clears and the byte is processed.
  - out_valid and err are never asserted together. Completion, duplicate and illegal-channel events are mutually exclusive by construction.

## Timing
- Reset values: output_data=24'h000000, out_valid=0, err=0, err_code=2'b00, mask=0, counter=0, state IDLE.
- Reset mid-frame drops the partial frame with no err.
- Latency: out_valid rises on the clock edge that samples the completing byte. output_data is registered and visible the same cycle as out_valid.
- Throughput: one byte per clock. Back-to-back frames need no idle gap. A 3-cycle frame yields one out_valid every 3 cycles.
- Timeout: with the last accepted byte at edge N, err/11 is asserted after edge N+TIMEOUT, provided no byte is accepted in between.
- No backpressure; the input is always accepted.

## Configuration
- OUTPUT_DEMUXER_TIMEOUT_EN:
  - Defined: the timeout counter and err_code 11 exist as described.
  - Undefined: there is no counter, and TIMEOUT is unused. A partial frame waits indefinitely, and err_code is never 11.

## Structure
- Shared package link_pkg holds:
  - CH_IDLE=4'h0, CH_LO=4'h1, CH_MID=4'h2, CH_HI=4'h3;
  - FILLER_BYTE=8'hEE;
  - ERR_BADCH=2'b01, ERR_DUP=2'b10, ERR_TIMEOUT=2'b11.
- The transmitter muxer uses the same constants.
- One sub-module, frame_timeout:
  - Inputs clear and tick; output expired.
  - Width $clog2(TIMEOUT+1).
  - Instantiated only under OUTPUT_DEMUXER_TIMEOUT_EN.

## Test plan
- Reset, then bytes (1,0x11),(2,0x22),(3,0x33) on consecutive cycles → out_valid pulse on the 3rd edge, output_data=24'h332211, err never set.
- Out-of-order (3,0xC3),(1,0xA1),(idle 0xEE),(2,0xB2) → single out_valid, output_data=24'hC3B2A1, no err.
- (1,0x01),(1,0x02),(2,0x03),(3,0x04) → err/10 on the 2nd byte, then output_data=24'h040302.
- (5,0x55) mid-frame, then the frame completes → err/01 pulse, mask unaffected, output_data correct.
- TIMEOUT=4: (1,0xAA) then 4 idle cycles → err/11 four edges after; a subsequent (2,x),(3,y) does not complete the frame.
- Assert arst after (1,x),(2,y), release, send (3,z) → no out_valid; all outputs at reset values during reset.
